// File: rtl/lynx_pkg.sv
// Shared constants and types for the Lynx clock-enable logic.
// CPU divider ratios and the speed-mode encoding used by the enable generator.
package lynx_pkg;

    localparam int CPU_DIV_4M = 12;
    localparam int CPU_DIV_6M = 8;
    localparam int CC_BITS    = 4;

    typedef enum logic {
        SPEED_4M = 1'b0,
        SPEED_6M = 1'b1
    } speed_t;

    function automatic logic [CC_BITS-1:0] cpu_div(input speed_t spd);
        return (spd == SPEED_6M) ? CC_BITS'(CPU_DIV_6M) : CC_BITS'(CPU_DIV_4M);
    endfunction

endpackage

// File: rtl/enables_if.sv
// Control inputs and enable/reset outputs of the clock-enable generator.
// master drives the requests; slave is the enables block itself.
interface enables_if;

    logic turbo;
    logic hold;
    logic rreq;
    logic ce12M;
    logic ce6M;
    logic cpuPe;
    logic cpuNe;
    logic speed;
    logic rst;

    modport master (
        output turbo, hold, rreq,
        input  ce12M, ce6M, cpuPe, cpuNe, speed, rst
    );

    modport slave (
        input  turbo, hold, rreq,
        output ce12M, ce6M, cpuPe, cpuNe, speed, rst
    );

endinterface

// File: rtl/enables_rststretch.sv
// Power-on / soft-reset stretcher: a saturating counter whose
// not-yet-saturated state is the stretched system reset.
module rststretch #(
    parameter int POR_BITS = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic rreq,
    output logic rst
);

    logic [POR_BITS-1:0] por_reg;
    logic [POR_BITS-1:0] por_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            por_reg <= '0;
        end else begin
            por_reg <= por_next;
        end
    end

    // A soft-reset request restarts the stretch even while counting.
    always_comb begin
        por_next = por_reg;
        if (rreq) begin
            por_next = '0;
        end else if (!(&por_reg)) begin
            por_next = por_reg + 1'b1;
        end
    end

    assign rst = ~(&por_reg);

endmodule

// File: rtl/enables.sv
// Video pixel/fetch enables, switchable 4/6 MHz CPU edge enables with freeze,
// and the stretched system reset, all derived from the 48 MHz clock.
module enables
    import lynx_pkg::*;
#(
    parameter int POR_BITS = 16
) (
    input  logic     clock,
    input  logic     reset,
    enables_if.slave bus
);

    logic [2:0]         vc_reg;
    logic [2:0]         vc_next;
    logic [CC_BITS-1:0] cc_reg;
    logic [CC_BITS-1:0] cc_next;
    speed_t             speed_reg;
    speed_t             speed_next;

    logic [CC_BITS-1:0] div_n;
    logic [CC_BITS-1:0] cc_last;
    logic [CC_BITS-1:0] cc_half;

    assign div_n   = cpu_div(speed_reg);
    assign cc_last = div_n - 4'd1;
    assign cc_half = (div_n >> 1) - 4'd1;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vc_reg    <= '0;
            cc_reg    <= '0;
            speed_reg <= SPEED_4M;
        end else begin
            vc_reg    <= vc_next;
            cc_reg    <= cc_next;
            speed_reg <= speed_next;
        end
    end

    // Next state: speed may only change at a wrap so a CPU period is never cut short.
    always_comb begin
        vc_next    = vc_reg + 3'd1;
        cc_next    = cc_reg;
        speed_next = speed_reg;
        if (!bus.hold) begin
            if (cc_reg == cc_last) begin
                cc_next    = '0;
                speed_next = speed_t'(bus.turbo);
            end else begin
                cc_next = cc_reg + 4'd1;
            end
        end
    end

    // Outputs decoded straight from registered state; hold only masks CPU edges.
    always_comb begin
        bus.ce12M = &vc_reg[1:0];
        bus.ce6M  = &vc_reg;
        bus.cpuPe = !bus.hold && (cc_reg == cc_half);
        bus.cpuNe = !bus.hold && (cc_reg == cc_last);
        bus.speed = speed_reg;
    end

    rststretch #(
        .POR_BITS(POR_BITS)
    ) u_rststretch (
        .clock(clock),
        .reset(reset),
        .rreq (bus.rreq),
        .rst  (bus.rst)
    );

endmodule
